// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage access controller: turns EX/MEM load/store requests into a req/ack
// memory transaction, stalls upstream while busy, and registers MEM/WB contents.
module mem_stage_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] reg_read_data_2_in,
  input  logic [4:0]        EX_MEM_RegisterRd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [4:0]        MEM_WB_RegisterRd_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              misalign_q, misalign_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [4:0]        rd_q, rd_d;

  logic access;
  logic aligned;

  assign access  = MemRead_in | MemWrite_in;
  assign aligned = (ALU_result_in[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access && aligned) state_d = BUSY;
      BUSY: if (mem_ack)           state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Default is to hold everything; each branch overrides only what it changes.
  always_comb begin
    mem_stall    = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    misalign_d   = 1'b0;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          reg_write_d  = 1'b0;
          mem_to_reg_d = 1'b0;
          if (aligned) begin
            mem_stall   = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite_in;
            mem_addr_d  = ADDR_W'(ALU_result_in);
            mem_wdata_d = reg_read_data_2_in;
          end else begin
            misalign_d = 1'b1;
          end
        end else begin
          reg_write_d  = RegWrite_in;
          mem_to_reg_d = MemtoReg_in;
          alu_result_d = ALU_result_in;
          rd_d         = EX_MEM_RegisterRd_in;
          read_data_d  = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          reg_write_d  = RegWrite_in;
          mem_to_reg_d = MemtoReg_in;
          alu_result_d = ALU_result_in;
          rd_d         = EX_MEM_RegisterRd_in;
          if (!mem_we_q) read_data_d = mem_rdata;
        end else begin
          mem_stall    = 1'b1;
          reg_write_d  = 1'b0;
          mem_to_reg_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      misalign_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      misalign_q   <= misalign_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
    end
  end

  assign mem_req               = mem_req_q;
  assign mem_we                = mem_we_q;
  assign mem_addr              = mem_addr_q;
  assign mem_wdata             = mem_wdata_q;
  assign misalign_err          = misalign_q;
  assign RegWrite_out          = reg_write_q;
  assign MemtoReg_out          = mem_to_reg_q;
  assign mem_read_data_out     = read_data_q;
  assign ALU_result_out        = alu_result_q;
  assign MEM_WB_RegisterRd_out = rd_q;

endmodule
